// File: rtl/pc_stack_pkg.sv
// Shared types and helpers for the program counter with return-address stack.
// Holds the operation encoding, its priority decoder and the stack-pointer width rule.
package pc_stack_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_LOAD,
        OP_RET,
        OP_CALL,
        OP_CLR
    } op_t;

    // The pointer must be able to count 0..depth inclusive.
    function automatic int sp_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Only the highest-priority control bit is honoured in a cycle.
    function automatic op_t decode_op(input logic clr, input logic call, input logic ret,
                                      input logic load, input logic inc);
        if (clr)       return OP_CLR;
        else if (call) return OP_CALL;
        else if (ret)  return OP_RET;
        else if (load) return OP_LOAD;
        else if (inc)  return OP_INC;
        else           return OP_HOLD;
    endfunction

endpackage

// File: rtl/lifo_stack.sv
// Return-address LIFO: push ignored when full, pop ignored when empty.
// dout always shows the top entry; the entry array itself is never reset.
module lifo_stack
    import pc_stack_pkg::*;
#(
    parameter int  W     = 16,
    parameter int  DEPTH = 4,
    localparam int SP_W  = sp_width(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            push,
    input  logic            pop,
    input  logic [W-1:0]    din,
    output logic [W-1:0]    dout,
    output logic [SP_W-1:0] sp,
    output logic            full,
    output logic            empty
);

    logic [W-1:0] mem [DEPTH];

    assign full  = (sp == SP_W'(DEPTH));
    assign empty = (sp == '0);

    // Synchronous flush wins over push, which wins over pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                sp <= '0;
        else if (clr)           sp <= '0;
        else if (push && !full) sp <= sp + SP_W'(1);
        else if (pop && !empty) sp <= sp - SP_W'(1);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!clr && push && !full && sp == SP_W'(i))
                mem[i] <= din;
        end
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp == SP_W'(i + 1))
                dout = mem[i];
        end
    end

endmodule

// File: rtl/pc_stack.sv
// Program counter with clr/load/inc plus call/ret through a hardware return stack.
// out, sp and the sticky error flags are all registered.
module pc_stack
    import pc_stack_pkg::*;
#(
    parameter int  W     = 16,
    parameter int  DEPTH = 4,
    localparam int SP_W  = sp_width(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    input  logic            load,
    input  logic            call,
    input  logic            ret,
    input  logic [W-1:0]    in,
    output logic [W-1:0]    out,
    output logic [SP_W-1:0] sp,
    output logic            full,
    output logic            empty,
    output logic            overflow,
    output logic            underflow
);

    op_t          op;
    logic [W-1:0] top;
    logic [W-1:0] next_pc;

    assign op      = decode_op(clr, call, ret, load, inc);
    assign next_pc = out + W'(1);

    lifo_stack #(.W(W), .DEPTH(DEPTH)) u_stack (
        .clk   (clk),
        .rst   (rst),
        .clr   (op == OP_CLR),
        .push  (op == OP_CALL),
        .pop   (op == OP_RET),
        .din   (next_pc),
        .dout  (top),
        .sp    (sp),
        .full  (full),
        .empty (empty)
    );

    // A call on a full stack still jumps; only the return address is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (op)
                OP_CLR: begin
                    out       <= '0;
                    overflow  <= 1'b0;
                    underflow <= 1'b0;
                end
                OP_CALL: begin
                    out <= in;
                    if (full) overflow <= 1'b1;
                end
                OP_RET: begin
                    if (empty) underflow <= 1'b1;
                    else       out <= top;
                end
                OP_LOAD: out <= in;
                OP_INC:  out <= next_pc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench: stimulus queues hand-computed expectations, a monitor pops and compares.
module tb_pc_stack;

    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_CLR  = 5'b10000;
    localparam logic [4:0] C_CALL = 5'b01000;
    localparam logic [4:0] C_RET  = 5'b00100;
    localparam logic [4:0] C_LOAD = 5'b00010;
    localparam logic [4:0] C_INC  = 5'b00001;

    typedef struct {
        logic [15:0] out;
        logic [2:0]  sp;
        logic        ov;
        logic        un;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0, inc = 1'b0, load = 1'b0, call = 1'b0, ret = 1'b0;
    logic [15:0] in  = '0;
    logic [15:0] out;
    logic [2:0]  sp;
    logic        full, empty, overflow, underflow;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_bad = 0;
    event  chk_ev;

    pc_stack #(.W(16), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .inc       (inc),
        .load      (load),
        .call      (call),
        .ret       (ret),
        .in        (in),
        .out       (out),
        .sp        (sp),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Monitor: samples 1 time unit after each edge or async-reset check request.
    always begin
        @(posedge clk or chk_ev);
        #1;
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            logic  e_full, e_empty;
            e      = exp_q.pop_front();
            nm     = name_q.pop_front();
            e_full  = (e.sp == 3'd4);
            e_empty = (e.sp == 3'd0);
            n_vec++;
            if (out !== e.out || sp !== e.sp || full !== e_full || empty !== e_empty ||
                overflow !== e.ov || underflow !== e.un) begin
                n_bad++;
                $display("FAIL %s: got out=%h sp=%0d full=%b empty=%b ov=%b un=%b, want out=%h sp=%0d full=%b empty=%b ov=%b un=%b",
                         nm, out, sp, full, empty, overflow, underflow,
                         e.out, e.sp, e_full, e_empty, e.ov, e.un);
            end
        end
    end

    task automatic vec(input string nm, input logic [4:0] ctl, input logic [15:0] din,
                       input logic [15:0] e_out, input logic [2:0] e_sp,
                       input logic e_ov, input logic e_un);
        exp_t e;
        @(negedge clk);
        {clr, call, ret, load, inc} = ctl;
        in = din;
        e = '{e_out, e_sp, e_ov, e_un};
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        @(negedge clk);
        {clr, call, ret, load, inc} = C_NONE;
    endtask

    // Assert rst between edges and check the cleared state before the next edge.
    task automatic async_rst(input string nm);
        exp_t e;
        @(negedge clk);
        #2 rst = 1'b1;
        e = '{16'h0000, 3'd0, 1'b0, 1'b0};
        exp_q.push_back(e);
        name_q.push_back(nm);
        ->chk_ev;
        #2 rst = 1'b0;
    endtask

    initial begin
        exp_t e;
        #3;
        e = '{16'h0000, 3'd0, 1'b0, 1'b0};
        exp_q.push_back(e);
        name_q.push_back("reset_state");
        ->chk_ev;
        @(negedge clk);
        rst = 1'b0;

        vec("load_1234",   C_LOAD, 16'h1234, 16'h1234, 3'd0, 1'b0, 1'b0);
        async_rst("async_rst_1234");
        vec("load_ffff",   C_LOAD, 16'hFFFF, 16'hFFFF, 3'd0, 1'b0, 1'b0);
        vec("inc_wrap",    C_INC,  16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);

        vec("load_5",      C_LOAD, 16'h0005, 16'h0005, 3'd0, 1'b0, 1'b0);
        vec("prio_clr",    C_CLR | C_LOAD | C_INC, 16'h00AA, 16'h0000, 3'd0, 1'b0, 1'b0);
        vec("prio_load",   C_LOAD | C_INC, 16'h00AA, 16'h00AA, 3'd0, 1'b0, 1'b0);

        vec("load_10",     C_LOAD, 16'h0010, 16'h0010, 3'd0, 1'b0, 1'b0);
        vec("call_100",    C_CALL, 16'h0100, 16'h0100, 3'd1, 1'b0, 1'b0);
        vec("call_200",    C_CALL, 16'h0200, 16'h0200, 3'd2, 1'b0, 1'b0);
        vec("ret_0101",    C_RET,  16'h0000, 16'h0101, 3'd1, 1'b0, 1'b0);
        vec("ret_0011",    C_RET,  16'h0000, 16'h0011, 3'd0, 1'b0, 1'b0);

        vec("fill_1",      C_CALL, 16'h1000, 16'h1000, 3'd1, 1'b0, 1'b0);
        vec("fill_2",      C_CALL, 16'h2000, 16'h2000, 3'd2, 1'b0, 1'b0);
        vec("fill_3",      C_CALL, 16'h3000, 16'h3000, 3'd3, 1'b0, 1'b0);
        vec("fill_4",      C_CALL, 16'h4000, 16'h4000, 3'd4, 1'b0, 1'b0);
        vec("call_full",   C_CALL, 16'h0500, 16'h0500, 3'd4, 1'b1, 1'b0);
        vec("lifo_ret_1",  C_RET,  16'h0000, 16'h3001, 3'd3, 1'b1, 1'b0);
        vec("lifo_ret_2",  C_RET,  16'h0000, 16'h2001, 3'd2, 1'b1, 1'b0);
        vec("lifo_ret_3",  C_RET,  16'h0000, 16'h1001, 3'd1, 1'b1, 1'b0);
        vec("lifo_ret_4",  C_RET,  16'h0000, 16'h0012, 3'd0, 1'b1, 1'b0);
        vec("ov_hold",     C_INC,  16'h0000, 16'h0013, 3'd0, 1'b1, 1'b0);
        vec("clr_ov",      C_CLR,  16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);

        vec("load_42",     C_LOAD, 16'h0042, 16'h0042, 3'd0, 1'b0, 1'b0);
        vec("ret_empty",   C_RET,  16'h0000, 16'h0042, 3'd0, 1'b0, 1'b1);
        vec("load_50",     C_LOAD, 16'h0050, 16'h0050, 3'd0, 1'b0, 1'b1);
        vec("call_and_ret",C_CALL | C_RET, 16'h0300, 16'h0300, 3'd1, 1'b0, 1'b1);
        vec("ret_0051",    C_RET,  16'h0000, 16'h0051, 3'd0, 1'b0, 1'b1);
        vec("clr_un",      C_CLR,  16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);

        vec("load_ffff_2", C_LOAD, 16'hFFFF, 16'hFFFF, 3'd0, 1'b0, 1'b0);
        vec("call_wrap",   C_CALL, 16'h0007, 16'h0007, 3'd1, 1'b0, 1'b0);
        vec("ret_wrap",    C_RET,  16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);

        vec("un_set",      C_RET,  16'h0000, 16'h0000, 3'd0, 1'b0, 1'b1);
        vec("stk_1",       C_CALL, 16'h0A00, 16'h0A00, 3'd1, 1'b0, 1'b1);
        vec("stk_2",       C_CALL, 16'h0B00, 16'h0B00, 3'd2, 1'b0, 1'b1);
        vec("stk_3",       C_CALL, 16'h0C00, 16'h0C00, 3'd3, 1'b0, 1'b1);
        vec("stk_4",       C_CALL, 16'h0D00, 16'h0D00, 3'd4, 1'b0, 1'b1);
        vec("stk_ov",      C_CALL, 16'h0E00, 16'h0E00, 3'd4, 1'b1, 1'b1);
        vec("stk_ret",     C_RET,  16'h0000, 16'h0C01, 3'd3, 1'b1, 1'b1);
        async_rst("async_rst_stack");
        vec("ret_after_rst", C_RET, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b1);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised Hack-style program counter extended with a hardware return-address stack.
- Supports the classic clr / load / inc operations, plus call (push return address, jump) and ret (pop, jump back).
- Sits between the CPU jump logic and instruction ROM address; next-generation successor to the fixed-width PC.

Parameters:
W, 16, counter and address width in bits (>=2)
DEPTH, 4, number of return-address stack entries (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
clr  input  1  synchronous clear (Hack "reset" pin)
inc  input  1  increment out by 1
load  input  1  out <= in
call  input  1  push out+1, then out <= in
ret  input  1  pop top of stack into out
in  input  W  jump target
out  output  W  current PC
sp  output  $clog2(DEPTH+1)  number of valid stack entries
full  output  1  sp == DEPTH
empty  output  1  sp == 0
overflow  output  1  sticky: call attempted while full
underflow  output  1  sticky: ret attempted while empty

Behaviour:
- rst high (async, any time): out=0, sp=0, overflow=0, underflow=0 immediately. Stack contents are don't-care. Operation resumes on the first clk edge after rst falls.
- All other updates happen on the rising clk edge. Results are visible the same cycle after the edge (latency 1).
- Priority per edge: clr > call > ret > load > inc > hold. Only the winning operation takes effect.
- clr: out=0, sp=0, overflow=0, underflow=0.
- call, not full: stack[sp] = (out+1) mod 2^W; sp+1; out=in.
- call, full: stack and sp unchanged; out=in (jump still taken); overflow=1.
- ret, not empty: out=stack[sp-1]; sp-1.
- ret, empty: out holds; underflow=1.
- load: out=in. inc: out=(out+1) mod 2^W; all-ones wraps to 0.
- call and ret in the same cycle: call wins, ret ignored with no flag.
- Sticky flags clear only on rst or clr.
- full and empty are combinational from sp.
- out, sp and flags are registered; no combinational path from inputs to out.
- Push address arithmetic is W bits and wraps silently; no flag is raised.

Decomposition:
- Package pc_stack_pkg:
  - op enum {OP_HOLD, OP_INC, OP_LOAD, OP_RET, OP_CALL, OP_CLR}
  - priority-decode function (control bits -> op)
  - SP_W = $clog2(DEPTH+1) helper
- Sub-module lifo_stack:
  - parameters W, DEPTH
  - ports: clk, rst, push, pop, din, dout, sp, full, empty
  - ignores push when full and pop when empty
- pc_stack holds the counter register, op decode and sticky flags.

Test Plan:
- Reset and wrap: pulse rst mid-cycle with out=0x1234 -> out=0 and sp=0 before the next edge. load in=0xFFFF, then inc -> out=0x0000.
- Priority: clr=load=inc=1, in=0x00AA from out=5 -> out=0. Next cycle load=inc=1, in=0x00AA -> out=0x00AA.
- Nested calls (DEPTH=4): from out=0x0010, call in=0x0100, then call in=0x0200 -> sp=2, out=0x0200. Two rets -> out=0x0101 then 0x0011, sp=0, empty=1.
- Overflow: 4 calls fill the stack (full=1). A 5th call with in=0x0500 -> out=0x0500, sp=4, overflow=1. 4 rets return the 4 pushed addresses in LIFO order; overflow stays 1 until clr.
- Underflow and simultaneous: ret with sp=0 and out=0x0042 -> out=0x0042, underflow=1. call=ret=1 with in=0x0300 from out=0x0050 -> push 0x0051, out=0x0300, sp=1.
- Async reset mid-stack: with sp=3 and both flags set, assert rst between edges -> sp=0, out=0, flags=0 immediately. After release, ret -> underflow=1.
